// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display-side reader of the vector data RAM.
// Holds the 640x480@60 timing constants (10-bit, to match the h/v counters),
// the pixels-per-word constant and the 256-bit vector word type that the
// SIMD memory stage also uses.
package vga_pkg;

  localparam logic [9:0] H_ACT  = 10'd640;
  localparam logic [9:0] H_FP   = 10'd16;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] H_BP   = 10'd48;
  localparam logic [9:0] H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;  // 800

  localparam logic [9:0] V_ACT  = 10'd480;
  localparam logic [9:0] V_FP   = 10'd10;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] V_BP   = 10'd33;
  localparam logic [9:0] V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;  // 525

  localparam logic [9:0] H_SYNC_START = H_ACT + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_ACT + H_FP + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_ACT + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_ACT + V_FP + V_SYNC;

  localparam int PIX_PER_WORD = 32;

  // One RAM word: 32 grayscale pixels, byte 0 is the leftmost pixel.
  typedef logic [255:0] vec_word_t;

  // True when lo <= pos < hi.
  function automatic logic in_window(logic [9:0] pos, logic [9:0] lo, logic [9:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA 640x480@60 raster counters and raw sync/blank generation.
// Ports:
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   h, v        : current horizontal / vertical position (0..799, 0..524)
//   active      : h and v inside the visible 640x480 area
//   hsync_raw   : active-low horizontal sync, not yet registered
//   vsync_raw   : active-low vertical sync, not yet registered
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       active,
  output logic       hsync_raw,
  output logic       vsync_raw
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_TOT - 10'd1) begin
      h <= '0;
      v <= (v == V_TOT - 10'd1) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  assign active    = (h < H_ACT) && (v < V_ACT);
  assign hsync_raw = !in_window(h, H_SYNC_START, H_SYNC_END);
  assign vsync_raw = !in_window(v, V_SYNC_START, V_SYNC_END);

endmodule

// File: rtl/vga_vector_reader.sv
// Display-side reader of the vector data RAM. Fetches 256-bit words through
// the RAM's second read port, unpacks each into 32 grayscale pixels and shows
// an IMG_W x IMG_H framebuffer at the top-left of a 640x480@60 screen.
// Ports:
//   clk, rst_n      : pixel clock, asynchronous active-low reset
//   vga_addr        : word address to the RAM read port (held between reads)
//   vga_rdata       : RAM read data, valid RD_LAT clocks after vga_addr
//   vga_r/g/b       : gray pixel replicated on all three channels
//   vga_hsync/vsync : active-low syncs, aligned with the pixel
//   vga_blank_n     : high while the visible area is on the outputs
//   frame_start     : one-clock pulse while pixel (0,0) is on the outputs
module vga_vector_reader
  import vga_pkg::*;
#(
  parameter logic [15:0] FB_BASE = 16'h0000,
  parameter int          IMG_W   = 256,
  parameter int          IMG_H   = 256,
  parameter int          RD_LAT  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [15:0]  vga_addr,
  input  logic [255:0] vga_rdata,
  output logic [7:0]   vga_r,
  output logic [7:0]   vga_g,
  output logic [7:0]   vga_b,
  output logic         vga_hsync,
  output logic         vga_vsync,
  output logic         vga_blank_n,
  output logic         frame_start
);

  localparam int         WPL      = IMG_W / PIX_PER_WORD;
  localparam logic [4:0] WPL_W    = 5'(WPL);
  localparam logic [4:0] WPL_LAST = 5'(WPL - 1);
  localparam logic [15:0] WPL_A   = 16'(WPL);
  localparam logic [9:0] IMG_W_H  = 10'(IMG_W);
  localparam logic [9:0] IMG_H_V  = 10'(IMG_H);
  // Word 0 of the next line is fetched one word-time before the line wraps.
  localparam logic [9:0] W0_SLOT  = H_TOT - 10'd32;

  logic [9:0]  h;
  logic [9:0]  v;
  logic        active;
  logic        hsync_raw;
  logic        vsync_raw;

  vga_timing u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .h         (h),
    .v         (v),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  vec_word_t         next_word;
  vec_word_t         cur_word;
  logic              issue_q;     // a read was launched; aligned with vga_addr
  logic [RD_LAT-1:0] fetch_vld;   // top bit marks the cycle the data is on vga_rdata

  logic [9:0]  v_next;
  logic [4:0]  word_idx;
  logic        on_word_boundary;
  logic        line_in_img;
  logic        next_line_in_img;
  logic        issue_mid;
  logic        issue_w0;
  logic        issue;
  logic        load;
  logic [15:0] line_base;
  logic [15:0] next_line_base;
  logic [15:0] addr_next;
  logic [7:0]  pix_byte;
  logic [7:0]  pix_out;

  always_comb begin
    v_next           = (v == V_TOT - 10'd1) ? 10'd0 : v + 10'd1;
    word_idx         = h[9:5];
    on_word_boundary = (h[4:0] == 5'd0);
    line_in_img      = (v < IMG_H_V);
    next_line_in_img = (v_next < IMG_H_V);
    // While word k is being shown, word k+1 is fetched; the last word of the
    // line launches nothing, and the next line's word 0 goes out at W0_SLOT.
    issue_mid        = on_word_boundary && (word_idx < WPL_LAST) && line_in_img;
    issue_w0         = (h == W0_SLOT) && next_line_in_img;
    issue            = issue_mid || issue_w0;
    line_base        = FB_BASE + 16'(v) * WPL_A;
    next_line_base   = FB_BASE + 16'(v_next) * WPL_A;
    addr_next        = issue_w0 ? next_line_base
                                : line_base + {11'd0, word_idx} + 16'd1;
    load             = on_word_boundary && (word_idx < WPL_W) && line_in_img;
    // On a load cycle the first pixel comes straight from next_word so the
    // output register stays one clock behind h.
    pix_byte         = load ? next_word[7:0] : cur_word[7:0];
    pix_out          = (active && (h < IMG_W_H) && line_in_img) ? pix_byte : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_addr  <= FB_BASE;
      issue_q   <= 1'b0;
      fetch_vld <= '0;
      next_word <= '0;
      cur_word  <= '0;
    end else begin
      if (issue) vga_addr <= addr_next;
      issue_q      <= issue;
      fetch_vld[0] <= issue_q;
      for (int i = 1; i < RD_LAT; i++) fetch_vld[i] <= fetch_vld[i-1];
      if (fetch_vld[RD_LAT-1]) next_word <= vga_rdata;
      cur_word <= load ? (next_word >> 8) : (cur_word >> 8);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= 8'd0;
      vga_g       <= 8'd0;
      vga_b       <= 8'd0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= pix_out;
      vga_g       <= pix_out;
      vga_b       <= pix_out;
      vga_hsync   <= hsync_raw;
      vga_vsync   <= vsync_raw;
      vga_blank_n <= active;
      frame_start <= (h == 10'd0) && (v == 10'd0);
    end
  end

endmodule
